// File: rtl/seg_scan_595_mux.sv
// Multiplexed 7-segment scanner: shifts {segment, select} words into two chained 74HC595s,
// PWM-dims each digit through OE, and swaps in new display data only at the start of a frame.
module seg_scan_595_mux #(
  parameter int NUM_DIGITS     = 6,
  parameter int CLK_DIV        = 600,
  parameter int COMMON_ANODE   = 0,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    upd_valid_in,
  output logic                    upd_ready_out,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [3:0]              bright_in,
  output logic                    rclk_out,
  output logic                    sclk_out,
  output logic                    sdio_out,
  output logic                    oe_n_out,
  output logic                    frame_done_out
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_LATCH, ST_DWELL} state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h3F;  4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;  4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;  4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;  4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;  4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;  4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;  4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;  4'hF: hex_to_seg = 7'h71;
      default: hex_to_seg = 7'h00;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q;
  logic                    tick_s;
  logic [4:0]              cnt_q, cnt_d;
  logic [DIG_W-1:0]        digit_q, digit_d;
  logic [15:0]             word_q, word_d;
  logic                    sclk_q, sclk_d, sdio_q, sdio_d, rclk_q, rclk_d;
  logic                    oe_n_q, oe_n_d, fd_q, fd_d;
  logic                    pending_q;
  logic [4*NUM_DIGITS-1:0] stage_data_q, act_data_q, src_data_s;
  logic [NUM_DIGITS-1:0]   stage_dp_q, stage_blank_q, act_dp_q, act_blank_q;
  logic [NUM_DIGITS-1:0]   src_dp_s, src_blank_s;
  logic                    xfer_s, accept_s;
  logic [3:0]              nib_s;
  logic [7:0]              seg_raw_s, seg_s, sel_oh_s, sel_s;

  assign tick_s   = (div_q == DIV_LAST);
  assign accept_s = upd_valid_in & ~pending_q;
  assign xfer_s   = (state_q == ST_LOAD) && (digit_q == '0) && pending_q;

  // Tick divider: free-running, wraps after CLK_DIV clocks
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      div_q <= '0;
    end else if (tick_s) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Word for the current digit; a frame-start transfer uses the staged data directly
  always_comb begin
    src_data_s  = xfer_s ? stage_data_q  : act_data_q;
    src_dp_s    = xfer_s ? stage_dp_q    : act_dp_q;
    src_blank_s = xfer_s ? stage_blank_q : act_blank_q;
    nib_s       = src_data_s[{digit_q, 2'b00} +: 4];
    seg_raw_s   = src_blank_s[digit_q] ? 8'h00 : {src_dp_s[digit_q], hex_to_seg(nib_s)};
    seg_s       = (COMMON_ANODE != 0) ? ~seg_raw_s : seg_raw_s;
    sel_oh_s    = 8'h01 << digit_q;
    sel_s       = (SEL_ACTIVE_LOW != 0) ? ~sel_oh_s : sel_oh_s;
  end

  // Scan sequencer next-state and output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    word_d  = word_q;
    sclk_d  = sclk_q;
    sdio_d  = sdio_q;
    rclk_d  = rclk_q;
    oe_n_d  = oe_n_q;
    fd_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        word_d  = {seg_s, sel_s};
        cnt_d   = 5'd0;
        oe_n_d  = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick_s) begin
          if (cnt_q[0]) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            sdio_d = word_q[4'd15 - cnt_q[4:1]];
          end
          if (cnt_q == 5'd31) begin
            cnt_d   = 5'd0;
            state_d = ST_LATCH;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_LATCH: begin
        if (tick_s) begin
          if (cnt_q == 5'd0) begin
            rclk_d = 1'b1;
            cnt_d  = 5'd1;
          end else begin
            rclk_d  = 1'b0;
            cnt_d   = 5'd0;
            state_d = ST_DWELL;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DWELL: begin
        if (tick_s) begin
          // d=15 can never be below a 4-bit brightness, so OE is released on the last tick
          oe_n_d = ~(cnt_q[3:0] < bright_in);
          if (cnt_q[3:0] == 4'd15) begin
            cnt_d   = 5'd0;
            state_d = ST_LOAD;
            digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
            fd_d    = (digit_q == DIG_LAST);
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and registered 595 pins
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      digit_q <= '0;
      word_q  <= 16'h0000;
      sclk_q  <= 1'b0;
      sdio_q  <= 1'b0;
      rclk_q  <= 1'b0;
      oe_n_q  <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      word_q  <= word_d;
      sclk_q  <= sclk_d;
      sdio_q  <= sdio_d;
      rclk_q  <= rclk_d;
      oe_n_q  <= oe_n_d;
      fd_q    <= fd_d;
    end
  end

  // Update handshake: staging capture and frame-start transfer to the active set
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pending_q     <= 1'b0;
      stage_data_q  <= '0;
      stage_dp_q    <= '0;
      stage_blank_q <= '1;
      act_data_q    <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '1;
    end else if (xfer_s) begin
      pending_q   <= 1'b0;
      act_data_q  <= stage_data_q;
      act_dp_q    <= stage_dp_q;
      act_blank_q <= stage_blank_q;
    end else if (accept_s) begin
      pending_q     <= 1'b1;
      stage_data_q  <= data_in;
      stage_dp_q    <= dp_in;
      stage_blank_q <= blank_in;
    end else begin
      pending_q <= pending_q;
    end
  end

  assign upd_ready_out  = ~pending_q;
  assign rclk_out       = rclk_q;
  assign sclk_out       = sclk_q;
  assign sdio_out       = sdio_q;
  assign oe_n_out       = oe_n_q;
  assign frame_done_out = fd_q;
endmodule

// File: tb/tb_seg_scan_595_mux.sv
// Directed bench for seg_scan_595_mux: decodes the serial 595 stream back into latched words
// and checks them, OE duty, frame timing and the update handshake against hand-computed values.
module tb_seg_scan_595_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic va = 1'b0, ra;
  logic [23:0] da = 24'h0;
  logic [5:0] dpa = 6'h0, bla = 6'h0;
  logic [3:0] bra = 4'd5;
  logic rclk_a, sclk_a, sdio_a, oe_a, fd_a;

  logic vb = 1'b0, rb;
  logic [11:0] db = 12'h0;
  logic [2:0] dpb = 3'h0, blb = 3'h0;
  logic [3:0] brb = 4'd15;
  logic rclk_b, sclk_b, sdio_b, oe_b, fd_b;

  seg_scan_595_mux #(.NUM_DIGITS(6), .CLK_DIV(4), .COMMON_ANODE(0), .SEL_ACTIVE_LOW(1)) dut_a (
    .clk_in(clk), .rst_in(rst), .upd_valid_in(va), .upd_ready_out(ra),
    .data_in(da), .dp_in(dpa), .blank_in(bla), .bright_in(bra),
    .rclk_out(rclk_a), .sclk_out(sclk_a), .sdio_out(sdio_a), .oe_n_out(oe_a),
    .frame_done_out(fd_a));

  seg_scan_595_mux #(.NUM_DIGITS(3), .CLK_DIV(4), .COMMON_ANODE(1), .SEL_ACTIVE_LOW(0)) dut_b (
    .clk_in(clk), .rst_in(rst), .upd_valid_in(vb), .upd_ready_out(rb),
    .data_in(db), .dp_in(dpb), .blank_in(blb), .bright_in(brb),
    .rclk_out(rclk_b), .sclk_out(sclk_b), .sdio_out(sdio_b), .oe_n_out(oe_b),
    .frame_done_out(fd_b));

  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [15:0] wq_a[$], wq_b[$];
  int fq_a[$], oq_a[$], fdt_a[$], fq_b[$];
  int fdc_a = 0, fdc_b = 0, oec_a = 0;
  logic [15:0] sh_a = 16'h0, sh_b = 16'h0;
  logic sp_a = 1'b0, rp_a = 1'b0, sp_b = 1'b0, rp_b = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Serial decoder for instance A: words, frame index and OE-low clocks of the preceding dwell
  always @(negedge clk) begin
    if (rst) begin
      sh_a = 16'h0; sp_a = 1'b0; rp_a = 1'b0; oec_a = 0;
    end else begin
      if (sclk_a && !sp_a) sh_a = {sh_a[14:0], sdio_a};
      if (rclk_a && !rp_a) begin
        wq_a.push_back(sh_a); fq_a.push_back(fdc_a); oq_a.push_back(oec_a); oec_a = 0;
      end else if (!oe_a) oec_a++;
      if (fd_a) begin fdc_a++; fdt_a.push_back(cyc); end
      sp_a = sclk_a; rp_a = rclk_a;
    end
  end

  // Serial decoder for instance B
  always @(negedge clk) begin
    if (rst) begin
      sh_b = 16'h0; sp_b = 1'b0; rp_b = 1'b0;
    end else begin
      if (sclk_b && !sp_b) sh_b = {sh_b[14:0], sdio_b};
      if (rclk_b && !rp_b) begin wq_b.push_back(sh_b); fq_b.push_back(fdc_b); end
      if (fd_b) fdc_b++;
      sp_b = sclk_b; rp_b = rclk_b;
    end
  end

  function automatic logic [15:0] getw(input bit b, input int f, input int j);
    int c = 0;
    if (b) begin
      for (int i = 0; i < wq_b.size(); i++)
        if (fq_b[i] == f) begin if (c == j) return wq_b[i]; c++; end
    end else begin
      for (int i = 0; i < wq_a.size(); i++)
        if (fq_a[i] == f) begin if (c == j) return wq_a[i]; c++; end
    end
    return 16'hxxxx;
  endfunction

  function automatic int geto(input int f, input int j);
    int c = 0;
    for (int i = 0; i < wq_a.size(); i++)
      if (fq_a[i] == f) begin if (c == j) return oq_a[i]; c++; end
    return -1;
  endfunction

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_fd(input bit b, input int tgt, input int budget);
    int n = 0;
    while (((b ? fdc_b : fdc_a) < tgt) && n < budget) begin step(); n++; end
    if ((b ? fdc_b : fdc_a) < tgt) begin
      n_cmp++; n_err++;
      $display("FAIL wait_frame_done: got frame %0d expected %0d", (b ? fdc_b : fdc_a), tgt);
    end
  endtask

  task automatic upd_a(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] bl,
                       input logic [3:0] br, output int f);
    int n = 0;
    while (!ra && n < 3000) begin step(); n++; end
    chk("ready_before_upd", ra, 1'b1);
    da = d; dpa = dp; bla = bl; bra = br; va = 1'b1;
    f = fdc_a;
    step();
    va = 1'b0;
    chk("ready_fall", ra, 1'b0);
  endtask

  typedef struct {
    logic [23:0] data;
    logic [5:0]  dp;
    logic [5:0]  blank;
    logic [3:0]  bright;
    logic [95:0] words;   // digit j at [16*j +: 16]
  } vec_t;
  vec_t vt[3];
  logic [15:0] dark_a[6];

  initial begin
    int f, f0, fb0, n, n0, cnt, fs;
    logic prev;
    vt[0] = '{24'h654321, 6'b000010, 6'b000000, 4'd15,
              {16'h7DDF, 16'h6DEF, 16'h66F7, 16'h4FFB, 16'hDBFD, 16'h06FE}};
    vt[1] = '{24'hFEDCBA, 6'b100001, 6'b000100, 4'd8,
              {16'hF1DF, 16'h79EF, 16'h5EF7, 16'h00FB, 16'h7CFD, 16'hF7FE}};
    vt[2] = '{24'h789000, 6'b111111, 6'b101010, 4'd1,
              {16'h00DF, 16'hFFEF, 16'h00F7, 16'hBFFB, 16'h00FD, 16'hBFFE}};
    dark_a = '{16'h00FE, 16'h00FD, 16'h00FB, 16'h00F7, 16'h00EF, 16'h00DF};

    repeat (3) step();
    chk("rst_rclk", rclk_a, 1'b0);
    chk("rst_sclk", sclk_a, 1'b0);
    chk("rst_sdio", sdio_a, 1'b0);
    chk("rst_oe_n", oe_a, 1'b1);
    chk("rst_frame_done", fd_a, 1'b0);
    chk("rst_ready", ra, 1'b1);
    rst = 1'b0;

    // Instance B: dark first frame, then common-anode / active-high-select update
    wait_fd(1'b1, 1, 2000);
    db = 12'h00A; dpb = 3'b000; blb = 3'b000; vb = 1'b1; fb0 = fdc_b;
    step();
    vb = 1'b0;
    chk("b_ready_fall", rb, 1'b0);

    wait_fd(1'b0, 2, 4000);
    wait_fd(1'b1, fb0 + 2, 2000);
    for (int j = 0; j < 6; j++) chk($sformatf("dark_w%0d", j), getw(1'b0, 0, j), dark_a[j]);
    chk("dark_oe_low_clks", geto(0, 1), 20);
    chk("frame_period", (fdt_a.size() >= 2) ? (fdt_a[1] - fdt_a[0]) : 0, 1200);
    chk("b_dark_w0", getw(1'b1, 0, 0), 16'hFF01);
    chk("b_dark_w1", getw(1'b1, 0, 1), 16'hFF02);
    chk("b_dark_w2", getw(1'b1, 0, 2), 16'hFF04);
    chk("b_hexA_w0", getw(1'b1, fb0 + 1, 0), 16'h8801);
    chk("b_hex0_w1", getw(1'b1, fb0 + 1, 1), 16'hC002);
    chk("b_hex0_w2", getw(1'b1, fb0 + 1, 2), 16'hC004);

    // Table-driven updates on instance A
    for (int i = 0; i < 3; i++) begin
      upd_a(vt[i].data, vt[i].dp, vt[i].blank, vt[i].bright, f);
      wait_fd(1'b0, f + 2, 4000);
      for (int j = 0; j < 6; j++)
        chk($sformatf("v%0d_w%0d", i, j), getw(1'b0, f + 1, j), vt[i].words[16*j +: 16]);
      chk($sformatf("v%0d_oe_low_clks", i), geto(f + 1, 3), {26'd0, vt[i].bright, 2'b00});
      chk($sformatf("v%0d_ready_back", i), ra, 1'b1);
    end

    // Mid-frame update: ready timing, second valid ignored, old frame completes
    n0 = wq_a.size(); n = 0;
    while (wq_a.size() == n0 && n < 500) begin step(); n++; end
    da = 24'h111111; dpa = 6'h0; bla = 6'h0; bra = 4'd15; va = 1'b1; f0 = fdc_a;
    step();
    chk("t4_ready_fall", ra, 1'b0);
    da = 24'h222222;
    step(); step();
    va = 1'b0;
    n = 0;
    while (fdc_a == f0 && n < 1500) begin step(); n++; end
    chk("t4_ready_at_frame_done", ra, 1'b0);
    step();
    chk("t4_ready_after_load", ra, 1'b1);
    wait_fd(1'b0, f0 + 2, 3000);
    chk("t4_old_w5", getw(1'b0, f0, 5), 16'h00DF);
    chk("t4_new_w0", getw(1'b0, f0 + 1, 0), 16'h06FE);
    chk("t4_new_w1", getw(1'b0, f0 + 1, 1), 16'h06FD);

    // Brightness 0 keeps OE high all frame; raising to 8 mid-dwell applies from the next tick
    bra = 4'd0;
    wait_fd(1'b0, fdc_a + 1, 1500);
    cnt = 0; n = 0; fs = fdc_a;
    while (fdc_a == fs && n < 1500) begin if (!oe_a) cnt++; step(); n++; end
    chk("t6_dark_frame_oe", cnt, 0);
    n = 0; prev = rclk_a;
    while (!(prev && !rclk_a) && n < 500) begin prev = rclk_a; step(); n++; end
    repeat (10) step();
    bra = 4'd8;
    cnt = 0; n = 0;
    while (!rclk_a && n < 500) begin step(); if (!oe_a) cnt++; n++; end
    chk("t6_bright8_mid_dwell", cnt, 24);

    // Reset during SHIFT of digit 3 with an update pending
    wait_fd(1'b0, fdc_a + 1, 1500);
    n0 = wq_a.size();
    da = 24'h333333; bla = 6'h0; va = 1'b1;
    step();
    va = 1'b0;
    chk("t5_pending", ra, 1'b0);
    n = 0;
    while (wq_a.size() < n0 + 3 && n < 1000) begin step(); n++; end
    n = 0;
    while (!sclk_a && n < 50) begin step(); n++; end
    chk("t5_in_shift_sclk", sclk_a, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_rst_sclk", sclk_a, 1'b0);
    chk("t5_rst_rclk", rclk_a, 1'b0);
    chk("t5_rst_sdio", sdio_a, 1'b0);
    chk("t5_rst_oe_n", oe_a, 1'b1);
    chk("t5_rst_ready", ra, 1'b1);
    chk("t5_rst_frame_done", fd_a, 1'b0);
    wq_a.delete(); fq_a.delete(); oq_a.delete();
    repeat (3) step();
    rst = 1'b0;
    n = 0;
    while (wq_a.size() < 7 && n < 2000) begin step(); n++; end
    chk("t5_restart_w0", (wq_a.size() > 0) ? wq_a[0] : 16'hxxxx, 16'h00FE);
    chk("t5_restart_w1", (wq_a.size() > 1) ? wq_a[1] : 16'hxxxx, 16'h00FD);
    chk("t5_next_frame_w0", (wq_a.size() > 6) ? wq_a[6] : 16'hxxxx, 16'h00FE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
